// File: rtl/div_pkg.sv
// Shared types and constants for the divider result BCD stage.
// Holds FSM state encoding, default widths and the divide-by-zero digit code.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIV_WIDTH  = 8;
  localparam int         BCD_DIGITS = 3;
  localparam logic [3:0] DBZ_DIGIT  = 4'hF;

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step: add 3 to every digit >= 5, then shift {bcd,bin} left.
// Ports: bcd/bin in, bcd_next/bin_next out.
module bcd_dabble_step #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] bcd,
  input  logic [WIDTH-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd_next,
  output logic [WIDTH-1:0]    bin_next
);

  logic [4*DIGITS-1:0]       adj;
  logic [4*DIGITS+WIDTH-1:0] cat;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // The top bit of the widest digit falls off; with enough digits it is always zero.
  assign cat = {adj, bin} << 1;
  assign {bcd_next, bin_next} = cat;

endmodule

// File: rtl/div_result_bcd.sv
// Divider result stage: converts the quotient (and optionally the remainder) to packed BCD.
// Ports: clk, rst, in_valid/in_ready + quotient/remainder/div_by_zero in,
// out_valid/out_ready + q_bcd/r_bcd/out_dbz out. DIV_REM_BCD_EN adds the r_bcd path.
module div_result_bcd
  import div_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    quotient,
  input  logic [WIDTH-1:0]    remainder,
  input  logic                div_by_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] q_bcd,
`ifdef DIV_REM_BCD_EN
  output logic [4*DIGITS-1:0] r_bcd,
`endif
  output logic                out_dbz
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam logic [4*DIGITS-1:0] DBZ_CODE = {DIGITS{DBZ_DIGIT}};

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    q_bin;
  logic [WIDTH-1:0]    q_bin_nx;
  logic [4*DIGITS-1:0] q_bcd_nx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q_step (
    .bcd      (q_bcd),
    .bin      (q_bin),
    .bcd_next (q_bcd_nx),
    .bin_next (q_bin_nx)
  );

`ifdef DIV_REM_BCD_EN
  logic [WIDTH-1:0]    r_bin;
  logic [WIDTH-1:0]    r_bin_nx;
  logic [4*DIGITS-1:0] r_bcd_nx;

  bcd_dabble_step #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r_step (
    .bcd      (r_bcd),
    .bin      (r_bin),
    .bcd_next (r_bcd_nx),
    .bin_next (r_bin_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
    end else if (state == IDLE && in_valid) begin
      r_bin <= remainder;
      r_bcd <= div_by_zero ? DBZ_CODE : '0;
    end else if (state == SHIFT) begin
      r_bin <= r_bin_nx;
      r_bcd <= r_bcd_nx;
    end
  end
`else
  logic unused_rem;
  assign unused_rem = ^remainder;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      q_bin   <= '0;
      q_bcd   <= '0;
      out_dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_bin   <= quotient;
            out_dbz <= div_by_zero;
            cnt     <= CNT_MAX;
            if (div_by_zero) begin
              q_bcd <= DBZ_CODE;
              state <= DONE;
            end else begin
              q_bcd <= '0;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          q_bin <= q_bin_nx;
          q_bcd <= q_bcd_nx;
          cnt   <= cnt - 1'b1;
          if (cnt == '0)
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed self-checking bench for div_result_bcd.
// Covers latency, full-scale/zero, div-by-zero, back-pressure, mid-conversion reset.
module tb_div_result_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] q_bcd;
`ifdef DIV_REM_BCD_EN
  logic [11:0] r_bcd;
`endif
  logic        out_dbz;

  int checks = 0;
  int errors = 0;
  logic bad_digit = 1'b0;

  always #5 clk = ~clk;

  div_result_bcd dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q_bcd       (q_bcd),
`ifdef DIV_REM_BCD_EN
    .r_bcd       (r_bcd),
`endif
    .out_dbz     (out_dbz)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Any digit above 9 outside the dbz code is an error.
  always @(negedge clk) begin
    if (!out_dbz) begin
      for (int i = 0; i < 3; i++)
        if (q_bcd[4*i +: 4] > 4'd9) bad_digit <= 1'b1;
    end
  end

  task automatic send(input logic [7:0] q, input logic [7:0] r,
                      input logic dbz, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    quotient = q;
    remainder = r;
    div_by_zero = dbz;
    check("accept_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("back_to_idle", 32'(in_ready), 32'd1);
    check("valid_dropped", 32'(out_valid), 32'd0);
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    quotient = '0;
    remainder = '0;
    div_by_zero = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q_bcd", 32'(q_bcd), 32'h0);
    check("rst_dbz", 32'(out_dbz), 32'd0);
    rst = 1'b0;

    // 100 / 5
    send(8'd20, 8'd0, 1'b0, lat);
    check("t1_latency", 32'(lat), 32'd9);
    check("t1_q_bcd", 32'(q_bcd), 32'h020);
    check("t1_dbz", 32'(out_dbz), 32'd0);
`ifdef DIV_REM_BCD_EN
    check("t1_r_bcd", 32'(r_bcd), 32'h000);
`endif
    release_out();

    send(8'd255, 8'd3, 1'b0, lat);
    check("t2_latency", 32'(lat), 32'd9);
    check("t2_q_full", 32'(q_bcd), 32'h255);
`ifdef DIV_REM_BCD_EN
    check("t2_r_bcd", 32'(r_bcd), 32'h003);
`endif
    release_out();
    send(8'd0, 8'd0, 1'b0, lat);
    check("t2_q_zero", 32'(q_bcd), 32'h000);
    release_out();
    send(8'd138, 8'd0, 1'b0, lat);
    check("t2_q_138", 32'(q_bcd), 32'h138);
    release_out();

    send(8'd9, 8'd4, 1'b1, lat);
    check("t3_latency", 32'(lat), 32'd1);
    check("t3_q_code", 32'(q_bcd), 32'hFFF);
    check("t3_dbz", 32'(out_dbz), 32'd1);
`ifdef DIV_REM_BCD_EN
    check("t3_r_code", 32'(r_bcd), 32'hFFF);
`endif
    release_out();

    // Back-pressure: new input offered while DONE is held.
    send(8'd37, 8'd0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      quotient = 8'(100 + i);
      div_by_zero = 1'b0;
      @(negedge clk);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_ready", 32'(in_ready), 32'd0);
      check("t4_hold_q", 32'(q_bcd), 32'h037);
    end
    in_valid = 1'b0;
    release_out();
    @(negedge clk);
    check("t4_not_taken", 32'(q_bcd), 32'h037);

    // Reset during the fourth shift step.
    @(negedge clk);
    in_valid = 1'b1;
    quotient = 8'd200;
    div_by_zero = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_in_shift", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_idle", 32'(in_ready), 32'd1);
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_q", 32'(q_bcd), 32'h000);
    send(8'd5, 8'd0, 1'b0, lat);
    check("t5_q_after", 32'(q_bcd), 32'h005);
    check("t5_latency", 32'(lat), 32'd9);
    release_out();

`ifdef DIV_REM_BCD_EN
    send(8'd7, 8'd1, 1'b0, lat);
    check("t6_lat_a", 32'(lat), 32'd9);
    check("t6_q_a", 32'(q_bcd), 32'h007);
    check("t6_r_a", 32'(r_bcd), 32'h001);
    release_out();
    send(8'd199, 8'd0, 1'b0, lat);
    check("t6_lat_b", 32'(lat), 32'd9);
    check("t6_q_b", 32'(q_bcd), 32'h199);
    check("t6_r_b", 32'(r_bcd), 32'h000);
    release_out();
`endif

    check("digits_in_range", 32'(bad_digit), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
